// File: rtl/ucie_pt_pkg.sv
// Shared constants for the RX-side multi-lane point test: sideband codes, FSM states and
// comparator control words.
package ucie_pt_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StWaitTestReq,
        StWaitClrReq,
        StSendClrResp,
        StCompare,
        StWaitEndReq,
        StSendEndResp,
        StFinish,
        StTimeout
    } pt_state_e;

    localparam logic [3:0] MsgTestReq    = 4'b0001;
    localparam logic [3:0] MsgTestResp   = 4'b0010;
    localparam logic [3:0] MsgClrReq     = 4'b0011;
    localparam logic [3:0] MsgClrResp    = 4'b0100;
    localparam logic [3:0] MsgResultReq  = 4'b0101;
    localparam logic [3:0] MsgResultResp = 4'b0110;
    localparam logic [3:0] MsgEndReq     = 4'b0111;
    localparam logic [3:0] MsgEndResp    = 4'b1000;

    localparam logic [1:0] ModeLfsr   = 2'b00;
    localparam logic [1:0] ModeLaneId = 2'b01;

    localparam logic [1:0] CwOff    = 2'b00;
    localparam logic [1:0] CwClear  = 2'b01;
    localparam logic [1:0] CwLfsr   = 2'b10;
    localparam logic [1:0] CwLaneId = 2'b11;

    localparam logic [3:0] RefVoltCompare = 4'b1000;

    // Valtrain (mode 1x) uses the valid-pattern compare path, so the lane comparators stay off.
    function automatic logic [1:0] mode_to_cw(input logic [1:0] mode);
        if (mode[1]) begin
            return CwOff;
        end
        return (mode == ModeLaneId) ? CwLaneId : CwLfsr;
    endfunction

    function automatic logic tmo_active(input pt_state_e st);
        return (st == StWaitTestReq) || (st == StWaitClrReq) ||
               (st == StCompare) || (st == StWaitEndReq);
    endfunction

endpackage

// File: rtl/tx_pt_rx_multilane_if.sv
// Sideband request/response bundle between the partner-facing sideband logic and the
// point-test responder.
interface tx_pt_rx_multilane_if #(
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned MSG_W     = 4
) ();

    logic [MSG_W-1:0]     i_sb_msg;
    logic                 i_sb_msg_valid;
    logic                 i_valid_tx;
    logic                 i_busy_negedge_detected;
    logic [MSG_W-1:0]     o_sb_msg;
    logic [NUM_LANES-1:0] o_sb_data;
    logic                 o_valid_rx;

    modport master (
        output i_sb_msg,
        output i_sb_msg_valid,
        output i_valid_tx,
        output i_busy_negedge_detected,
        input  o_sb_msg,
        input  o_sb_data,
        input  o_valid_rx
    );

    modport slave (
        input  i_sb_msg,
        input  i_sb_msg_valid,
        input  i_valid_tx,
        input  i_busy_negedge_detected,
        output o_sb_msg,
        output o_sb_data,
        output o_valid_rx
    );

endinterface

// File: rtl/pt_lane_err_counter.sv
// Per-lane saturating mismatch counter; holds at all-ones instead of wrapping.
module pt_lane_err_counter #(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             err_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && err_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tx_pt_rx_multilane.sv
// RX-side point-test responder: answers the partner's sideband requests, counts per-lane
// compare errors and reports a per-lane pass vector.
module tx_pt_rx_multilane
    import ucie_pt_pkg::*;
#(
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned MSG_W     = 4,
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned TMO_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [1:0]           i_mode,
    input  logic [NUM_LANES-1:0] i_lane_err,
    input  logic [CNT_W-1:0]     i_err_threshold,
    input  logic [TMO_W-1:0]     i_tmo_limit,
    tx_pt_rx_multilane_if.slave  sb_if,
    output logic [1:0]           o_cmp_cw,
    output logic                 o_cmp_valid_en,
    output logic [3:0]           o_ref_voltage,
    output logic                 o_test_ack_rx,
    output logic                 o_timeout
);

    pt_state_e            state_q, state_d;
    logic [MSG_W-1:0]     msg_q, msg_d;
    logic [NUM_LANES-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 pend_q, pend_d;
    logic [1:0]           cw_q, cw_d;
    logic                 ven_q, ven_d;
    logic [3:0]           ref_q, ref_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;

    logic                 send_req, cnt_clr, cnt_en, tmo_hit, resp_done;
    logic                 req_test, req_clr, req_result, req_end;
    logic [CNT_W-1:0]     cnt [NUM_LANES];
    logic [NUM_LANES-1:0] lane_pass;

    assign req_test   = sb_if.i_sb_msg_valid && (sb_if.i_sb_msg == MSG_W'(MsgTestReq));
    assign req_clr    = sb_if.i_sb_msg_valid && (sb_if.i_sb_msg == MSG_W'(MsgClrReq));
    assign req_result = sb_if.i_sb_msg_valid && (sb_if.i_sb_msg == MSG_W'(MsgResultReq));
    assign req_end    = sb_if.i_sb_msg_valid && (sb_if.i_sb_msg == MSG_W'(MsgEndReq));

    assign tmo_hit   = tmo_active(state_q) && (i_tmo_limit != '0) &&
                       ((tmo_q + TMO_W'(1)) == i_tmo_limit);
    // Response is complete once it was launched and the partner has consumed it.
    assign resp_done = !valid_q && !pend_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        pt_lane_err_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i (clk),
            .rst_i (rst),
            .clr_i (cnt_clr),
            .en_i  (cnt_en),
            .err_i (i_lane_err[g]),
            .cnt_o (cnt[g])
        );
        assign lane_pass[g] = (cnt[g] <= i_err_threshold);
    end

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        data_d   = data_q;
        cw_d     = cw_q;
        ven_d    = ven_q;
        ref_d    = ref_q;
        send_req = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_clr = 1'b1;
                if (i_en) state_d = StWaitTestReq;
            end
            StWaitTestReq: begin
                if (req_test) begin
                    msg_d    = MSG_W'(MsgTestResp);
                    send_req = 1'b1;
                    state_d  = StWaitClrReq;
                end else if (tmo_hit) begin
                    state_d = StTimeout;
                end
            end
            StWaitClrReq: begin
                if (req_clr) begin
                    msg_d    = MSG_W'(MsgClrResp);
                    send_req = 1'b1;
                    cnt_clr  = 1'b1;
                    cw_d     = CwClear;
                    state_d  = StSendClrResp;
                end else if (tmo_hit) begin
                    state_d = StTimeout;
                end
            end
            StSendClrResp: begin
                if (resp_done) begin
                    ref_d   = RefVoltCompare;
                    cw_d    = mode_to_cw(i_mode);
                    ven_d   = i_mode[1];
                    state_d = StCompare;
                end
            end
            StCompare: begin
                if (req_result) begin
                    cw_d     = CwOff;
                    ven_d    = 1'b0;
                    msg_d    = MSG_W'(MsgResultResp);
                    data_d   = lane_pass;
                    send_req = 1'b1;
                    state_d  = StWaitEndReq;
                end else begin
                    cnt_en = 1'b1;
                    if (tmo_hit) state_d = StTimeout;
                end
            end
            StWaitEndReq: begin
                if (req_end) begin
                    msg_d    = MSG_W'(MsgEndResp);
                    send_req = 1'b1;
                    state_d  = StSendEndResp;
                end else if (tmo_hit) begin
                    state_d = StTimeout;
                end
            end
            StSendEndResp: begin
                if (resp_done) state_d = StFinish;
            end
            StFinish, StTimeout: begin
                state_d = state_q;
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StTimeout) begin
            cw_d  = CwOff;
            ven_d = 1'b0;
        end
        if (!i_en) begin
            state_d  = StIdle;
            send_req = 1'b0;
        end
        if (state_d == StIdle) begin
            msg_d  = '0;
            data_d = '0;
            cw_d   = CwOff;
            ven_d  = 1'b0;
            ref_d  = '0;
        end
    end

    // A request that collides with a busy TX or with a clear pulse waits in the pending flag.
    always_comb begin
        valid_d = valid_q;
        pend_d  = pend_q;
        if (sb_if.i_busy_negedge_detected) valid_d = 1'b0;
        if (pend_q && !sb_if.i_valid_tx) begin
            valid_d = 1'b1;
            pend_d  = 1'b0;
        end
        if (send_req) begin
            if (sb_if.i_busy_negedge_detected || sb_if.i_valid_tx) begin
                pend_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                pend_d  = 1'b0;
            end
        end
        if ((state_d == StIdle) || (state_d == StTimeout)) begin
            valid_d = 1'b0;
            pend_d  = 1'b0;
        end
    end

    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (tmo_active(state_q)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            msg_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            cw_q    <= CwOff;
            ven_q   <= 1'b0;
            ref_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            cw_q    <= cw_d;
            ven_q   <= ven_d;
            ref_q   <= ref_d;
            tmo_q   <= tmo_d;
        end
    end

    assign sb_if.o_sb_msg   = msg_q;
    assign sb_if.o_sb_data  = data_q;
    assign sb_if.o_valid_rx = valid_q;
    assign o_cmp_cw         = cw_q;
    assign o_cmp_valid_en   = ven_q;
    assign o_ref_voltage    = ref_q;
    assign o_test_ack_rx    = (state_q == StFinish);
    assign o_timeout        = (state_q == StTimeout);

endmodule

// File: tb/tb_tx_pt_rx_multilane.sv
// Directed + randomized bench for tx_pt_rx_multilane with a per-lane error-count model.
module tb_tx_pt_rx_multilane;

    localparam int unsigned NL = 16;
    localparam int unsigned MW = 4;
    localparam int unsigned CW = 12;
    localparam int unsigned TW = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_en = 1'b0;
    logic [1:0]    i_mode = 2'b00;
    logic [NL-1:0] i_lane_err = '0;
    logic [CW-1:0] i_err_threshold = '0;
    logic [TW-1:0] i_tmo_limit = '0;
    logic [1:0]    o_cmp_cw;
    logic          o_cmp_valid_en;
    logic [3:0]    o_ref_voltage;
    logic          o_test_ack_rx;
    logic          o_timeout;

    int vectors = 0;
    int miscompares = 0;
    int err_cnt [NL];

    tx_pt_rx_multilane_if #(.NUM_LANES(NL), .MSG_W(MW)) sb_if ();

    tx_pt_rx_multilane #(
        .NUM_LANES (NL),
        .MSG_W     (MW),
        .CNT_W     (CW),
        .TMO_W     (TW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_en            (i_en),
        .i_mode          (i_mode),
        .i_lane_err      (i_lane_err),
        .i_err_threshold (i_err_threshold),
        .i_tmo_limit     (i_tmo_limit),
        .sb_if           (sb_if),
        .o_cmp_cw        (o_cmp_cw),
        .o_cmp_valid_en  (o_cmp_valid_en),
        .o_ref_voltage   (o_ref_voltage),
        .o_test_ack_rx   (o_test_ack_rx),
        .o_timeout       (o_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec table: mode 00 -> LFSR cw 10, 01 -> lane-ID cw 11, 1x -> valtrain, comparators off.
    function automatic logic [1:0] exp_cw(input logic [1:0] mode);
        if (mode[1]) return 2'b00;
        return (mode == 2'b01) ? 2'b11 : 2'b10;
    endfunction

    function automatic logic [NL-1:0] exp_pass(input logic [CW-1:0] thr);
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++) begin
            int sat;
            sat  = (err_cnt[i] > CNT_MAX) ? CNT_MAX : err_cnt[i];
            r[i] = (sat <= int'(thr));
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NL; i++) err_cnt[i] = 0;
    endtask

    task automatic apply_err(input logic [NL-1:0] v);
        i_lane_err = v;
        tick();
        for (int i = 0; i < NL; i++) if (v[i]) err_cnt[i]++;
        i_lane_err = '0;
    endtask

    task automatic send_msg(input logic [3:0] code);
        sb_if.i_sb_msg       = code;
        sb_if.i_sb_msg_valid = 1'b1;
        tick();
        sb_if.i_sb_msg_valid = 1'b0;
        sb_if.i_sb_msg       = '0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (sb_if.o_valid_rx !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(sb_if.o_valid_rx), 32'd1);
    endtask

    task automatic busy_pulse(input string tag);
        sb_if.i_busy_negedge_detected = 1'b1;
        tick();
        sb_if.i_busy_negedge_detected = 1'b0;
        check({tag, "_clr"}, 32'(sb_if.o_valid_rx), 32'd0);
    endtask

    task automatic finish_resp(input string tag, input logic [3:0] exp_msg);
        wait_valid(tag);
        check({tag, "_msg"}, 32'(sb_if.o_sb_msg), 32'(exp_msg));
        busy_pulse(tag);
    endtask

    task automatic enter_compare(input logic [1:0] mode);
        int n = 0;
        while (o_cmp_cw !== exp_cw(mode) && n < 20) begin
            tick();
            n++;
        end
        check("cmp_cw", 32'(o_cmp_cw), 32'(exp_cw(mode)));
        check("cmp_ref", 32'(o_ref_voltage), 32'h8);
        check("cmp_ven", 32'(o_cmp_valid_en), 32'(mode[1]));
        clear_model();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_msg"}, 32'(sb_if.o_sb_msg), 32'd0);
        check({tag, "_data"}, 32'(sb_if.o_sb_data), 32'd0);
        check({tag, "_valid"}, 32'(sb_if.o_valid_rx), 32'd0);
        check({tag, "_cw"}, 32'(o_cmp_cw), 32'd0);
        check({tag, "_ven"}, 32'(o_cmp_valid_en), 32'd0);
        check({tag, "_ref"}, 32'(o_ref_voltage), 32'd0);
        check({tag, "_ack"}, 32'(o_test_ack_rx), 32'd0);
        check({tag, "_tmo"}, 32'(o_timeout), 32'd0);
    endtask

    task automatic start_test(input logic [1:0] mode);
        i_mode = mode;
        i_en   = 1'b1;
        tick();
        send_msg(4'b0001);
        finish_resp("test_resp", 4'b0010);
        send_msg(4'b0011);
        check("clr_cw", 32'(o_cmp_cw), 32'h1);
        finish_resp("clr_resp", 4'b0100);
        enter_compare(mode);
    endtask

    task automatic end_test(input logic [NL-1:0] exp_data);
        int n = 0;
        send_msg(4'b0101);
        check("result_cw", 32'(o_cmp_cw), 32'd0);
        check("result_ven", 32'(o_cmp_valid_en), 32'd0);
        wait_valid("result");
        check("result_msg", 32'(sb_if.o_sb_msg), 32'h6);
        check("result_data", 32'(sb_if.o_sb_data), 32'(exp_data));
        busy_pulse("result");
        send_msg(4'b0111);
        finish_resp("end_resp", 4'b1000);
        while (o_test_ack_rx !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("finish_ack", 32'(o_test_ack_rx), 32'd1);
        check("finish_tmo", 32'(o_timeout), 32'd0);
        i_en = 1'b0;
        tick();
        check_idle("post_end");
    endtask

    initial begin
        int n;
        logic [CW-1:0] thr;
        logic [1:0] mode;
        sb_if.i_sb_msg                = '0;
        sb_if.i_sb_msg_valid          = 1'b0;
        sb_if.i_valid_tx              = 1'b0;
        sb_if.i_busy_negedge_detected = 1'b0;
        clear_model();

        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("idle");

        // Clean full flow, LFSR mode.
        start_test(2'b00);
        end_test(16'hFFFF);

        // Threshold 3: lane 5 takes 4 errors (fails), lane 2 takes 3 (passes).
        start_test(2'b01);
        for (int k = 0; k < 4; k++) apply_err(NL'(1 << 5) | ((k < 3) ? NL'(1 << 2) : NL'(0)));
        i_err_threshold = 12'd3;
        end_test(16'hFFDF);

        // Clear request collides with a busy clear pulse; valtrain mode.
        i_mode = 2'b10;
        i_en   = 1'b1;
        tick();
        send_msg(4'b0001);
        wait_valid("coll_test");
        sb_if.i_sb_msg                = 4'b0011;
        sb_if.i_sb_msg_valid          = 1'b1;
        sb_if.i_busy_negedge_detected = 1'b1;
        tick();
        sb_if.i_sb_msg_valid          = 1'b0;
        sb_if.i_busy_negedge_detected = 1'b0;
        check("coll_first", 32'(sb_if.o_valid_rx), 32'd0);
        tick();
        check("coll_second", 32'(sb_if.o_valid_rx), 32'd1);
        check("coll_msg", 32'(sb_if.o_sb_msg), 32'h4);
        busy_pulse("coll");
        enter_compare(2'b10);
        for (int k = 0; k < 40; k++) apply_err(NL'($urandom & $urandom & $urandom));
        i_err_threshold = CW'($urandom_range(0, 8));
        end_test(exp_pass(i_err_threshold));

        // Clear response held back while the TX side is busy for 5 cycles.
        i_mode = 2'b00;
        i_en   = 1'b1;
        tick();
        send_msg(4'b0001);
        finish_resp("hold_test", 4'b0010);
        sb_if.i_valid_tx = 1'b1;
        send_msg(4'b0011);
        check("hold_c0", 32'(sb_if.o_valid_rx), 32'd0);
        for (int k = 1; k < 5; k++) begin
            tick();
            check("hold_cn", 32'(sb_if.o_valid_rx), 32'd0);
        end
        sb_if.i_valid_tx = 1'b0;
        finish_resp("hold_resp", 4'b0100);
        enter_compare(2'b00);
        for (int k = 0; k < 30; k++) apply_err(NL'($urandom & $urandom));
        i_err_threshold = CW'($urandom_range(0, 10));
        end_test(exp_pass(i_err_threshold));

        // Randomized runs across modes and thresholds.
        for (int r = 0; r < 4; r++) begin
            mode = 2'($urandom_range(0, 3));
            start_test(mode);
            for (int k = 0; k < 60; k++) apply_err(NL'($urandom & $urandom & $urandom));
            thr = CW'($urandom_range(0, 14));
            i_err_threshold = thr;
            end_test(exp_pass(thr));
        end

        // Timeout waiting for the clear request.
        i_tmo_limit = 16'd100;
        i_mode = 2'b00;
        i_en   = 1'b1;
        tick();
        send_msg(4'b0001);
        n = 0;
        while (o_timeout !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'd100);
        check("tmo_valid", 32'(sb_if.o_valid_rx), 32'd0);
        check("tmo_cw", 32'(o_cmp_cw), 32'd0);
        check("tmo_ack", 32'(o_test_ack_rx), 32'd0);
        i_en = 1'b0;
        tick();
        check_idle("tmo_exit");
        i_tmo_limit = '0;

        // Unqualified / unknown codes are ignored; enable drop aborts from COMPARE.
        start_test(2'b00);
        sb_if.i_sb_msg = 4'b0101;
        tick();
        tick();
        tick();
        sb_if.i_sb_msg = 4'b0111;
        sb_if.i_sb_msg_valid = 1'b1;
        tick();
        sb_if.i_sb_msg_valid = 1'b0;
        sb_if.i_sb_msg = '0;
        check("ignore_msg", 32'(sb_if.o_sb_msg), 32'h4);
        check("ignore_cw", 32'(o_cmp_cw), 32'h2);
        check("ignore_valid", 32'(sb_if.o_valid_rx), 32'd0);
        i_en = 1'b0;
        tick();
        check_idle("abort");

        // Saturation: 5000 errors on lane 0 must stick at 4095.
        start_test(2'b00);
        i_lane_err = NL'(1);
        repeat (5000) tick();
        i_lane_err = '0;
        err_cnt[0] = 5000;
        i_err_threshold = 12'd4094;
        end_test(16'hFFFE);

        // Reset in the middle of a test overrides everything.
        start_test(2'b01);
        i_lane_err = NL'($urandom);
        rst = 1'b1;
        tick();
        check_idle("mid_rst");
        rst = 1'b0;
        i_lane_err = '0;
        i_en = 1'b0;
        tick();
        check_idle("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tx_pt_rx_multilane.md
TX_PT_RX_MULTILANE -- requirements
Module: tx_pt_rx_multilane

Interface
REQ-001 Parameter NUM_LANES, default 16, number of mainband lanes compared and reported.
REQ-002 Parameter MSG_W, default 4, sideband message code width.
REQ-003 Parameter CNT_W, default 12, per-lane error counter width.
REQ-004 Parameter TMO_W, default 16, timeout counter width.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 i_en  in  1  test enable; deassertion aborts to IDLE.
REQ-008 i_mode  in  2  00 LFSR, 01 per-lane ID, 1x valtrain.
REQ-009 i_sb_msg, i_sb_msg_valid  in  MSG_W, 1  received sideband message and its qualifier.
REQ-010 i_valid_tx, i_busy_negedge_detected  in  1, 1  TX-side sideband request and sideband-done pulse.
REQ-011 i_lane_err  in  NUM_LANES  per-cycle per-lane mismatch pulses from comparators.
REQ-012 i_err_threshold  in  CNT_W  max errors tolerated per lane.
REQ-013 i_tmo_limit  in  TMO_W  cycles allowed waiting for any partner request; 0 disables timeout.
REQ-014 o_sb_msg, o_sb_data, o_valid_rx  out  MSG_W, NUM_LANES, 1  response message, per-lane pass vector, send request.
REQ-015 o_cmp_cw, o_cmp_valid_en  out  2, 1  comparator control word, valtrain compare enable.
REQ-016 o_ref_voltage  out  4  receiver reference control.
REQ-017 o_test_ack_rx, o_timeout  out  1, 1  test completed; test aborted by timeout.

Function
REQ-018 States: IDLE, WAIT_TEST_REQ, WAIT_CLR_REQ, SEND_CLR_RESP, COMPARE, WAIT_END_REQ, SEND_END_RESP, FINISH, TIMEOUT.
REQ-019 A request is accepted only when i_sb_msg_valid=1 and i_sb_msg matches; other codes are ignored.
REQ-020 IDLE -> WAIT_TEST_REQ when i_en=1.
REQ-021 WAIT_TEST_REQ: on 0001 load o_sb_msg=0010, raise send, go WAIT_CLR_REQ.
REQ-022 WAIT_CLR_REQ: on 0011 load o_sb_msg=0100, raise send, clear all error counters, set o_cmp_cw=01, go SEND_CLR_RESP.
REQ-023 SEND_CLR_RESP -> COMPARE on the cycle after o_valid_rx falls; on entry set o_ref_voltage=1000 and o_cmp_cw=10/11/00 for mode 00/01/1x, with o_cmp_valid_en=1 only for 1x.
REQ-024 COMPARE: each lane counter increments on i_lane_err, saturating at all-ones.
REQ-025 COMPARE: on 0101 freeze counters, set o_cmp_cw=00 and o_cmp_valid_en=0, load o_sb_msg=0110, load o_sb_data[i]=1 iff counter[i] <= i_err_threshold, raise send, go WAIT_END_REQ.
REQ-026 WAIT_END_REQ: on 0111 load o_sb_msg=1000, raise send, go SEND_END_RESP.
REQ-027 SEND_END_RESP -> FINISH when o_valid_rx falls; o_test_ack_rx=1 in FINISH until i_en=0.
REQ-028 Send handshake: o_valid_rx rises on the cycle after the send request if i_valid_tx=0; otherwise a pending flag holds the request until i_valid_tx=0; o_valid_rx clears on i_busy_negedge_detected.
REQ-029 i_busy_negedge_detected together with a new send request: clear first, assert o_valid_rx one cycle later.
REQ-030 Timeout counter runs in WAIT_TEST_REQ, WAIT_CLR_REQ, COMPARE and WAIT_END_REQ, restarts on each state entry, and is held in all other states; reaching i_tmo_limit (non-zero) -> TIMEOUT.
REQ-031 TIMEOUT: o_timeout=1, comparators disabled, no send; remain until i_en=0.
REQ-032 i_en=0 in any state -> IDLE next cycle; a pending send is dropped and o_valid_rx cleared.
REQ-033 IDLE drives all outputs to reset values.

Reset
REQ-034 On rst=1: state IDLE, all outputs 0, counters, pending flag and timeout counter 0.
REQ-035 rst mid-test overrides all inputs within one cycle.

Structure
REQ-036 Message codes, state encoding and mode/cw constants go in shared package ucie_pt_pkg.
REQ-037 Per-lane saturating counters go in sub-module pt_lane_err_counter, instantiated NUM_LANES times by generate.

Verification
REQ-038 Full flow, mode 00, no errors: codes 0001/0011/0101/0111 -> responses 0010/0100/0110/1000, o_sb_data=16'hFFFF, o_test_ack_rx=1.
REQ-039 Threshold 3; lane 5 gets 4 errors and lane 2 gets 3 -> o_sb_data=16'hFFDF.
REQ-040 Clear response with i_valid_tx=1 for 5 cycles -> o_valid_rx asserted only after i_valid_tx falls.
REQ-041 i_tmo_limit=100, no 0011 -> o_timeout=1 after 100 WAIT_CLR_REQ cycles; i_en=0 -> IDLE.
REQ-042 0101 with i_sb_msg_valid=0 -> ignored; i_en drop in COMPARE -> IDLE, all outputs 0.
REQ-043 Lane with 5000 errors, CNT_W=12 -> counter saturates at 4095, no wrap.
